// File: rtl/cache_pkg.sv
// Shared cache replacement types: way/PLRU widths, controller FSM states and request ops.
package cache_pkg;

  localparam int NUM_WAYS = 4;

  typedef logic [1:0] way_t;
  typedef logic [2:0] plru_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    LOOKUP = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    TOUCH = 1'b0,
    ALLOC = 1'b1
  } op_t;

endpackage

// File: rtl/way_victim_ctrl_if.sv
// Request/response bus between the tag-compare stage, the miss handler and way_victim_ctrl.
interface way_victim_ctrl_if #(
  parameter int SET_BITS = 6
);
  import cache_pkg::*;

  logic                req_valid;
  logic                req_ready;
  op_t                 req_op;
  logic [SET_BITS-1:0] req_set;
  way_t                req_way;
  logic [NUM_WAYS-1:0] req_vbits;
  logic                rsp_valid;
  logic                rsp_ready;
  way_t                rsp_way;
  logic                rsp_evict;

  modport master (
    output req_valid, req_op, req_set, req_way, req_vbits, rsp_ready,
    input  req_ready, rsp_valid, rsp_way, rsp_evict
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way, req_vbits, rsp_ready,
    output req_ready, rsp_valid, rsp_way, rsp_evict
  );

endinterface

// File: rtl/plru_tree.sv
// Combinational 4-way tree-PLRU: victim selection and state update for an accessed way.
// Build option PLRU_INVALID_FIRST_EN: prefer the lowest-indexed invalid way as victim.
module plru_tree
  import cache_pkg::*;
(
  input  plru_t               bits,
  input  way_t                access_way,
  input  logic [NUM_WAYS-1:0] vbits,
  output way_t                victim,
  output plru_t               next_bits
);

  way_t plru_victim;

  // bits = {b2, b1, b0}: b0 picks the pair, b1/b2 pick the way within it
  always_comb begin
    plru_victim = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
  end

`ifdef PLRU_INVALID_FIRST_EN
  always_comb begin
    victim = plru_victim;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!vbits[i]) begin
        victim = way_t'(i);
      end
    end
  end
`else
  logic unused_vbits;
  assign unused_vbits = ^vbits;
  assign victim       = plru_victim;
`endif

  // Point the tree away from the accessed way
  always_comb begin
    next_bits = bits;
    case (access_way)
      2'd0: begin next_bits[0] = 1'b1; next_bits[1] = 1'b1; end
      2'd1: begin next_bits[0] = 1'b1; next_bits[1] = 1'b0; end
      2'd2: begin next_bits[0] = 1'b0; next_bits[2] = 1'b1; end
      2'd3: begin next_bits[0] = 1'b0; next_bits[2] = 1'b0; end
      default: next_bits = bits;
    endcase
  end

endmodule

// File: rtl/way_victim_ctrl.sv
// Per-set tree-PLRU replacement controller: touch on hit, victim choice on allocate.
// Build option PLRU_INVALID_FIRST_EN (handled inside plru_tree).
module way_victim_ctrl
  import cache_pkg::*;
#(
  parameter int SET_BITS = 6
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  output logic             init_done,
  way_victim_ctrl_if.slave bus
);

  localparam logic [SET_BITS-1:0] SWEEP_LAST = '1;

  state_t              state_reg, state_next;
  logic [SET_BITS-1:0] sweep_cnt_reg;
  logic                init_done_reg;
  op_t                 op_reg;
  logic [SET_BITS-1:0] set_reg;
  way_t                way_reg;
  logic [NUM_WAYS-1:0] vbits_reg;
  way_t                rsp_way_reg;
  logic                rsp_evict_reg;

  plru_t               plru_mem [2**SET_BITS];
  plru_t               cur_bits;
  plru_t               next_bits;
  way_t                victim;
  way_t                access_way;
  logic                mem_we;
  logic [SET_BITS-1:0] mem_addr;
  plru_t               mem_wdata;
  logic                req_fire;

  assign cur_bits   = plru_mem[set_reg];
  assign access_way = (op_reg == ALLOC) ? victim : way_reg;
  assign mem_addr   = (state_reg == INIT) ? sweep_cnt_reg : set_reg;
  assign mem_wdata  = (state_reg == INIT) ? plru_t'(0) : next_bits;
  assign req_fire   = (state_reg == IDLE) && bus.req_valid;

  plru_tree u_plru_tree (
    .bits       (cur_bits),
    .access_way (access_way),
    .vbits      (vbits_reg),
    .victim     (victim),
    .next_bits  (next_bits)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_we        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_reg)
      INIT: begin
        mem_we = 1'b1;
        if (sweep_cnt_reg == SWEEP_LAST) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        // The write lands before IDLE, so a following request sees fresh bits
        mem_we     = 1'b1;
        state_next = (op_reg == ALLOC) ? RESP : IDLE;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      sweep_cnt_reg <= '0;
      init_done_reg <= 1'b0;
      op_reg        <= TOUCH;
      set_reg       <= '0;
      way_reg       <= '0;
      vbits_reg     <= '0;
      rsp_way_reg   <= '0;
      rsp_evict_reg <= 1'b0;
    end else begin
      if (state_reg == INIT) begin
        sweep_cnt_reg <= sweep_cnt_reg + SET_BITS'(1);
        if (sweep_cnt_reg == SWEEP_LAST) begin
          init_done_reg <= 1'b1;
        end
      end
      if (req_fire) begin
        op_reg    <= bus.req_op;
        set_reg   <= bus.req_set;
        way_reg   <= bus.req_way;
        vbits_reg <= bus.req_vbits;
      end
      if (state_reg == LOOKUP && op_reg == ALLOC) begin
        rsp_way_reg   <= victim;
        rsp_evict_reg <= vbits_reg[victim];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn && mem_we) begin
      plru_mem[mem_addr] <= mem_wdata;
    end
  end

  assign init_done     = init_done_reg;
  assign bus.rsp_way   = rsp_way_reg;
  assign bus.rsp_evict = rsp_evict_reg;

endmodule

// File: tb/tb_way_victim_ctrl.sv
// Self-checking bench for way_victim_ctrl: reset/INIT timing, directed vector table,
// randomized traffic against a recency-based PLRU model, and reset during a response.
module tb_way_victim_ctrl;
  import cache_pkg::*;

  localparam int SB   = 6;
  localparam int NSET = 1 << SB;

  logic clk;
  logic rstn;
  logic init_done;

  way_victim_ctrl_if #(.SET_BITS(SB)) bus ();

  way_victim_ctrl #(.SET_BITS(SB)) dut (
    .ACLK      (clk),
    .ARESETn   (rstn),
    .init_done (init_done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Model: per set, which pair (0 = ways 0/1, 1 = ways 2/3) was touched last,
  // and inside each pair which member was touched last. The victim is the
  // untouched member of the untouched pair.
  int m_side [NSET];
  int m_in   [NSET][2];

  function automatic void model_reset();
    for (int s = 0; s < NSET; s++) begin
      m_side[s]  = 1;
      m_in[s][0] = 1;
      m_in[s][1] = 1;
    end
  endfunction

  function automatic int model_victim(input int s, input logic [3:0] vb);
    int side;
`ifdef PLRU_INVALID_FIRST_EN
    for (int w = 0; w < 4; w++) begin
      if (!vb[w]) return w;
    end
`endif
    side = 1 - m_side[s];
    return 2 * side + (1 - m_in[s][side]);
  endfunction

  function automatic void model_update(input int s, input int w);
    m_side[s]       = w / 2;
    m_in[s][w / 2]  = w % 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_init(input string name);
    int  k;
    bit  seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (init_done === 1'b1) seen = 1'b1;
    end
    check({name, "_cycles"}, k, 64);
    check({name, "_ready"}, bus.req_ready, 1);
    $display("init %s: init_done after %0d cycles", name, k);
  endtask

  // One request; exp_way/exp_ev are only used for allocates.
  task automatic do_req(input op_t op, input int s, input int w, input logic [3:0] vb,
                        input int hold, input int exp_way, input bit exp_ev);
    int mv;
    mv = model_victim(s, vb);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = s[SB-1:0];
    bus.req_way   = w[1:0];
    bus.req_vbits = vb;
    bus.rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("req_ready_lookup", bus.req_ready, 0);
    check("rsp_valid_lookup", bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (op == TOUCH) begin
      check("touch_ready_back", bus.req_ready, 1);
      check("touch_no_rsp", bus.rsp_valid, 0);
      model_update(s, w);
    end else begin
      check("alloc_rsp_valid", bus.rsp_valid, 1);
      check("alloc_way", bus.rsp_way, exp_way);
      check("alloc_evict", bus.rsp_evict, exp_ev);
      check("alloc_ready_low", bus.req_ready, 0);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold_rsp_valid", bus.rsp_valid, 1);
        check("hold_way", bus.rsp_way, exp_way);
        check("hold_evict", bus.rsp_evict, exp_ev);
        check("hold_ready_low", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check("post_hs_rsp_valid", bus.rsp_valid, 0);
      check("post_hs_ready", bus.req_ready, 1);
      model_update(s, mv);
    end
    n_txn++;
    $display("txn %0d: %s set=%0d way=%0d vbits=%b hold=%0d exp_way=%0d exp_evict=%0d",
             n_txn, op.name(), s, w, vb, hold, exp_way, exp_ev);
  endtask

  typedef struct {
    op_t        op;
    int         set;
    int         way;
    logic [3:0] vb;
    int         hold;
    int         exp_way;
    bit         exp_ev;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = TOUCH;
    bus.req_set   = '0;
    bus.req_way   = '0;
    bus.req_vbits = '0;
    bus.rsp_ready = 1'b0;
    model_reset();

    tbl[0] = '{ALLOC, 5, 0, 4'b1111, 5, 0, 1'b1};
    tbl[1] = '{ALLOC, 5, 0, 4'b1111, 0, 2, 1'b1};
    tbl[2] = '{ALLOC, 5, 0, 4'b1111, 1, 1, 1'b1};
    tbl[3] = '{ALLOC, 5, 0, 4'b1111, 0, 3, 1'b1};
    tbl[4] = '{TOUCH, 9, 2, 4'b0000, 0, 0, 1'b0};
    tbl[5] = '{ALLOC, 9, 0, 4'b1111, 0, 0, 1'b1};
    tbl[6] = '{TOUCH, 9, 0, 4'b0000, 0, 0, 1'b0};
    tbl[7] = '{ALLOC, 9, 0, 4'b1111, 2, 3, 1'b1};
    tbl[8] = '{TOUCH, 0, 0, 4'b0000, 0, 0, 1'b0};
    tbl[9] = '{ALLOC, 63, 0, 4'b1111, 0, 0, 1'b1};
`ifdef PLRU_INVALID_FIRST_EN
    tbl[10] = '{ALLOC, 3, 0, 4'b1011, 0, 2, 1'b0};
    tbl[11] = '{ALLOC, 3, 0, 4'b0000, 0, 0, 1'b0};
`else
    tbl[10] = '{ALLOC, 3, 0, 4'b1011, 0, 0, 1'b1};
    tbl[11] = '{ALLOC, 3, 0, 4'b0000, 0, 2, 1'b0};
`endif

    // Reset values and first sweep
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_way", bus.rsp_way, 0);
    check("rst_rsp_evict", bus.rsp_evict, 0);
    check("rst_init_done", init_done, 0);
    rstn = 1'b1;
    wait_init("init");

    // Reset again mid-sweep: sweep restarts from entry 0
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("midsweep_init_done", init_done, 0);
    check("midsweep_ready", bus.req_ready, 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midsweep_rst_init_done", init_done, 0);
    rstn = 1'b1;
    wait_init("init_restart");

    // Directed vectors from a freshly swept array
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].op, tbl[i].set, tbl[i].way, tbl[i].vb, tbl[i].hold,
             tbl[i].exp_way, tbl[i].exp_ev);
    end

    // Random traffic, biased towards a few sets so state builds up
    for (int i = 0; i < 300; i++) begin
      op_t        op;
      int         s;
      int         w;
      logic [3:0] vb;
      int         mv;
      op = op_t'($urandom_range(0, 1));
      s  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, NSET - 1);
      w  = $urandom_range(0, 3);
      vb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) vb = 4'b1111;
      mv = model_victim(s, vb);
      do_req(op, s, w, vb, $urandom_range(0, 2), mv, vb[mv]);
    end

    // Reset while a response is pending
    bus.req_valid = 1'b1;
    bus.req_op    = ALLOC;
    bus.req_set   = 6'd5;
    bus.req_way   = 2'd0;
    bus.req_vbits = 4'b1111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_rsp_valid", bus.rsp_valid, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midop_rst_rsp_valid", bus.rsp_valid, 0);
    check("midop_rst_ready", bus.req_ready, 0);
    check("midop_rst_way", bus.rsp_way, 0);
    check("midop_rst_evict", bus.rsp_evict, 0);
    check("midop_rst_init_done", init_done, 0);
    rstn = 1'b1;
    $display("txn reset during RESP on set 5");
    wait_init("init_after_midop");
    model_reset();
    do_req(ALLOC, 5, 0, 4'b1111, 0, 0, 1'b1);
    do_req(ALLOC, 5, 0, 4'b1111, 0, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
